// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the CPU / program-loader memory arbiter:
// access op codes, IO window base, FSM encodings and grant ids.
package mem_arbiter_pkg;

  localparam int LDST_WID = 3;

  localparam logic [LDST_WID-1:0] LDST_LW  = 3'd0;
  localparam logic [LDST_WID-1:0] LDST_LH  = 3'd1;
  localparam logic [LDST_WID-1:0] LDST_LHU = 3'd2;
  localparam logic [LDST_WID-1:0] LDST_LB  = 3'd3;
  localparam logic [LDST_WID-1:0] LDST_LBU = 3'd4;
  localparam logic [LDST_WID-1:0] LDST_SW  = 3'd5;
  localparam logic [LDST_WID-1:0] LDST_SH  = 3'd6;
  localparam logic [LDST_WID-1:0] LDST_SB  = 3'd7;

  localparam logic [15:0] IO_BASE = 16'hffff;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LDR = 1'b1;

  function automatic logic is_load(
    input logic [LDST_WID-1:0] op
  );
    return (op == LDST_LW) || (op == LDST_LH) ||
           (op == LDST_LHU) || (op == LDST_LB) ||
           (op == LDST_LBU);
  endfunction

  function automatic logic is_part_store(
    input logic [LDST_WID-1:0] op
  );
    return (op == LDST_SH) || (op == LDST_SB);
  endfunction

endpackage

// File: rtl/mem_arbiter_lsu_align.sv
// Load extraction and sub-word store merge for the arbiter.
// Purely combinational; word is the raw word read from memory or IO.
module lsu_align
  import mem_arbiter_pkg::*;
(
  input  logic [LDST_WID-1:0] ldst,
  input  logic [1:0]          ofs,
  input  logic [31:0]         word,
  input  logic [31:0]         wdata,
  output logic [31:0]         load_data,
  output logic [31:0]         store_data
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    half   = ofs[1] ? word[31:16] : word[15:0];
    byte_v = word[{ofs, 3'b000} +: 8];
  end

  always_comb begin
    load_data = word;
    unique case (1'b1)
      ldst == LDST_LH:  load_data = {{16{half[15]}}, half};
      ldst == LDST_LHU: load_data = {16'h0, half};
      ldst == LDST_LB:  load_data = {{24{byte_v[7]}}, byte_v};
      ldst == LDST_LBU: load_data = {24'h0, byte_v};
      default:          load_data = word;
    endcase
  end

  always_comb begin
    store_data = word;
    unique case (1'b1)
      ldst == LDST_SH: begin
        if (ofs[1]) store_data[31:16] = wdata[15:0];
        else        store_data[15:0]  = wdata[15:0];
      end
      ldst == LDST_SB:
        store_data[{ofs, 3'b000} +: 8] = wdata[7:0];
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between CPU data accesses and the UART
// program loader, driving one word-wide memory plus an IO window.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic [LDST_WID-1:0] cpu_ldst,
  input  logic [31:0]         cpu_addr,
  input  logic [31:0]         cpu_wdata,
  output logic                cpu_ready,
  output logic [31:0]         cpu_rdata,
  input  logic                ldr_req,
  input  logic [31:0]         ldr_addr,
  input  logic [31:0]         ldr_wdata,
  output logic                ldr_ready,
  output logic [13:0]         mem_addr,
  output logic [31:0]         mem_din,
  output logic                mem_we,
  input  logic [31:0]         mem_dout,
  output logic                io_sel,
  output logic                io_we,
  input  logic [31:0]         io_rdata
);

  localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

  logic [1:0]          state;
  logic [1:0]          cnt;
  logic                gnt;
  logic                last_grant;
  logic [LDST_WID-1:0] ldst_q;
  logic [1:0]          ofs_q;
  logic                io_q;
  logic [31:0]         wdata_q;

  logic                any_req;
  logic                pick_ldr;
  logic [LDST_WID-1:0] w_ldst;
  logic [31:0]         w_addr;
  logic [31:0]         w_wdata;
  logic                w_io;
  logic                w_rd;
  logic [31:0]         rd_word;
  logic [31:0]         load_data;
  logic [31:0]         store_data;

  assign any_req  = cpu_req | ldr_req;
  assign pick_ldr = ldr_req &&
                    (!cpu_req || last_grant == GNT_CPU);

  // Loader traffic is treated as a plain full-word store.
  assign w_ldst  = pick_ldr ? LDST_SW : cpu_ldst;
  assign w_addr  = pick_ldr ? ldr_addr : cpu_addr;
  assign w_wdata = pick_ldr ? ldr_wdata : cpu_wdata;
  assign w_io    = w_addr[31:16] == IO_BASE;
  assign w_rd    = is_load(w_ldst) ||
                   (is_part_store(w_ldst) && !w_io);

  assign rd_word = io_q ? io_rdata : mem_dout;

  assign io_sel    = (state != S_IDLE) && io_q;
  assign mem_we    = (state == S_WR) && !io_q;
  assign io_we     = (state == S_WR) && io_q;
  assign cpu_ready = (state == S_RESP) && (gnt == GNT_CPU);
  assign ldr_ready = (state == S_RESP) && (gnt == GNT_LDR);

  lsu_align u_align (
    .ldst       (ldst_q),
    .ofs        (ofs_q),
    .word       (rd_word),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 2'd0;
      gnt        <= GNT_CPU;
      last_grant <= GNT_CPU;
      ldst_q     <= LDST_LW;
      ofs_q      <= 2'd0;
      io_q       <= 1'b0;
      wdata_q    <= 32'h0;
      mem_addr   <= 14'h0;
      mem_din    <= 32'h0;
      cpu_rdata  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt        <= pick_ldr;
            last_grant <= pick_ldr;
            ldst_q     <= w_ldst;
            ofs_q      <= w_addr[1:0];
            io_q       <= w_io;
            wdata_q    <= w_wdata;
            mem_addr   <= w_addr[15:2];
            mem_din    <= w_wdata;
            cnt        <= 2'd0;
            state      <= w_rd ? S_RD : S_WR;
          end
        end
        S_RD: begin
          if (cnt == RD_LAST) begin
            if (is_load(ldst_q)) begin
              cpu_rdata <= load_data;
              state     <= S_RESP;
            end else begin
              mem_din <= store_data;
              state   <= S_WR;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_WR:    state <= S_RESP;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (RD_LAT = 1)
// with a behavioural word memory and a fixed IO read value.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cpu_req = 1'b0;
  logic [LDST_WID-1:0] cpu_ldst = LDST_LW;
  logic [31:0]         cpu_addr = 32'h0;
  logic [31:0]         cpu_wdata = 32'h0;
  logic                cpu_ready;
  logic [31:0]         cpu_rdata;
  logic                ldr_req = 1'b0;
  logic [31:0]         ldr_addr = 32'h0;
  logic [31:0]         ldr_wdata = 32'h0;
  logic                ldr_ready;
  logic [13:0]         mem_addr;
  logic [31:0]         mem_din;
  logic                mem_we;
  logic [31:0]         mem_dout;
  logic                io_sel;
  logic                io_we;
  logic [31:0]         io_rdata;

  logic [31:0] mem [0:16383];
  int    we_cnt = 0, io_cnt = 0, sel_cnt = 0, rdy_cnt = 0;
  logic [13:0] wr_addr = 14'h0;
  logic [31:0] wr_data = 32'h0, io_wdata = 32'h0;
  int    n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];
  assign io_rdata = 32'h5A5A_1234;

  mem_arbiter #(.RD_LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_ldst  (cpu_ldst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .ldr_req   (ldr_req),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_ready (ldr_ready),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout),
    .io_sel    (io_sel),
    .io_we     (io_we),
    .io_rdata  (io_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
      we_cnt  = we_cnt + 1;
      wr_addr = mem_addr;
      wr_data = mem_din;
    end
    if (io_we) begin
      io_cnt   = io_cnt + 1;
      io_wdata = mem_din;
    end
    if (io_sel) sel_cnt = sel_cnt + 1;
    if (cpu_ready) rdy_cnt = rdy_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu_op(input logic [LDST_WID-1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        output int lat,
                        output logic [31:0] rd);
    @(negedge clk);
    cpu_req = 1'b1; cpu_ldst = op;
    cpu_addr = a;   cpu_wdata = d;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cpu_ready) begin
        lat = k;
        break;
      end
    end
    rd = cpu_rdata;
    cpu_req = 1'b0;
    if (lat == 0) check("cpu_timeout", 32'd0, 32'd1);
  endtask

  task automatic ldr_wr(input logic [31:0] a,
                        input logic [31:0] d,
                        output int lat);
    @(negedge clk);
    ldr_req = 1'b1; ldr_addr = a; ldr_wdata = d;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ldr_ready) begin
        lat = k;
        break;
      end
    end
    ldr_req = 1'b0;
    if (lat == 0) check("ldr_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat, we0, io0, sel0, r0, got;
    logic [31:0] rd;
    int seq [4];

    repeat (2) @(negedge clk);
    check("rst_cpu_ready", {31'h0, cpu_ready}, 32'd0);
    check("rst_ldr_ready", {31'h0, ldr_ready}, 32'd0);
    check("rst_mem_we", {31'h0, mem_we}, 32'd0);
    check("rst_io_we", {31'h0, io_we}, 32'd0);
    check("rst_mem_addr", {18'h0, mem_addr}, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    rst_n = 1'b1;

    we0 = we_cnt; io0 = io_cnt;
    cpu_op(LDST_SW, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd);
    check("sw_lat", lat, 32'd2);
    check("sw_we_cycles", we_cnt - we0, 32'd1);
    check("sw_addr", {18'h0, wr_addr}, 32'd4);
    check("sw_din", wr_data, 32'hDEAD_BEEF);
    check("sw_io_we", io_cnt - io0, 32'd0);

    ldr_wr(32'h0000_0010, 32'h1122_3344, lat);
    check("ldr_lat", lat, 32'd2);
    we0 = we_cnt;
    cpu_op(LDST_SB, 32'h0000_0013, 32'h0000_00AA, lat, rd);
    check("sb_lat", lat, 32'd3);
    check("sb_we_cycles", we_cnt - we0, 32'd1);
    check("sb_din", wr_data, 32'hAA22_3344);
    check("sb_mem", mem[4], 32'hAA22_3344);

    ldr_wr(32'h0000_0000, 32'h8000_F0F0, lat);
    cpu_op(LDST_LH, 32'h0000_0002, 32'h0, lat, rd);
    check("lh_lat", lat, 32'd2);
    check("lh_data", rd, 32'hFFFF_8000);
    cpu_op(LDST_LHU, 32'h0000_0002, 32'h0, lat, rd);
    check("lhu_data", rd, 32'h0000_8000);
    cpu_op(LDST_LB, 32'h0000_0000, 32'h0, lat, rd);
    check("lb_data", rd, 32'hFFFF_FFF0);
    cpu_op(LDST_LBU, 32'h0000_0001, 32'h0, lat, rd);
    check("lbu_data", rd, 32'h0000_00F0);
    cpu_op(LDST_LW, 32'h0000_0003, 32'h0, lat, rd);
    check("lw_data", rd, 32'h8000_F0F0);
    cpu_op(LDST_SH, 32'h0000_0002, 32'hFFFF_1234, lat, rd);
    check("sh_lat", lat, 32'd3);
    check("sh_mem", mem[0], 32'h1234_F0F0);
    check("rdata_hold", cpu_rdata, 32'h8000_F0F0);

    we0 = we_cnt; io0 = io_cnt; sel0 = sel_cnt;
    cpu_op(LDST_SW, 32'hFFFF_FF0C, 32'h0BAD_F00D, lat, rd);
    check("io_sw_lat", lat, 32'd2);
    check("io_sw_io_we", io_cnt - io0, 32'd1);
    check("io_sw_mem_we", we_cnt - we0, 32'd0);
    check("io_sw_sel", {31'h0, sel_cnt > sel0}, 32'd1);
    check("io_sw_data", io_wdata, 32'h0BAD_F00D);
    cpu_op(LDST_LW, 32'hFFFF_0000, 32'h0, lat, rd);
    check("io_lw_data", rd, 32'h5A5A_1234);
    io0 = io_cnt;
    cpu_op(LDST_SB, 32'hFFFF_0001, 32'h0000_00AB, lat, rd);
    check("io_sb_lat", lat, 32'd2);
    check("io_sb_data", io_wdata, 32'h0000_00AB);
    check("io_sb_io_we", io_cnt - io0, 32'd1);

    do_reset();
    @(negedge clk);
    ldr_req = 1'b1; ldr_addr = 32'h100; ldr_wdata = 32'hCAFE_0001;
    cpu_req = 1'b1; cpu_ldst = LDST_SW;
    cpu_addr = 32'h200; cpu_wdata = 32'hBEEF_0002;
    got = 0;
    for (int k = 0; k < 60 && got < 4; k++) begin
      @(negedge clk);
      if (ldr_ready) begin seq[got] = 1; got++; end
      else if (cpu_ready) begin seq[got] = 0; got++; end
    end
    ldr_req = 1'b0; cpu_req = 1'b0;
    check("rr_count", got, 32'd4);
    check("rr_0_ldr", seq[0], 32'd1);
    check("rr_1_cpu", seq[1], 32'd0);
    check("rr_2_ldr", seq[2], 32'd1);
    check("rr_3_cpu", seq[3], 32'd0);
    check("rr_ldr_mem", mem[64], 32'hCAFE_0001);
    check("rr_cpu_mem", mem[128], 32'hBEEF_0002);

    repeat (2) @(negedge clk);
    ldr_wr(32'h0000_0020, 32'h5566_7788, lat);
    we0 = we_cnt; r0 = rdy_cnt;
    @(negedge clk);
    cpu_req = 1'b1; cpu_ldst = LDST_SB;
    cpu_addr = 32'h20; cpu_wdata = 32'h11;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_we", we_cnt - we0, 32'd0);
    check("rst_mid_rdy", rdy_cnt - r0, 32'd0);
    check("rst_mid_mem", mem[8], 32'h5566_7788);
    rst_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cpu_ready) begin lat = k; break; end
    end
    cpu_req = 1'b0;
    check("regrant_lat", lat, 32'd3);
    check("regrant_we", we_cnt - we0, 32'd1);
    @(negedge clk);
    check("regrant_mem", mem[8], 32'h5566_7711);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
